demo_sequencer: RTL and testbench

- Frame-synchronous scheduler that shares the RGB output path between NUM_DEMOS pattern generators (RGB panel cycle, gradients and similar).
- Selects one active demo and dwells on it for a set number of frames. It then fades to black, switches source on a frame boundary, and fades back in.
- Advances automatically or on next/prev requests from the PS/button glue.
- Sits between the demo sources and the HDMI encoder input.

---
 rtl/demo_pkg.sv | 16 +
 rtl/demo_fade_scaler.sv | 30 +++
 rtl/demo_sequencer.sv | 147 ++++++++++++++
 tb/tb_demo_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared types and width helpers for the demo sequencer.
package demo_pkg;

    typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} demo_state_t;

    // Fade level spans 0..2**fade_log2 inclusive.
    function automatic int unsigned level_w(input int unsigned fade_log2);
        return fade_log2 + 1;
    endfunction

    // Counter/index width, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demo_fade_scaler.sv
// One colour channel: registered multiply by fade level and shift, blanked outside active video.
module demo_fade_scaler
    import demo_pkg::*;
#(
    parameter int unsigned COLSPC    = 10,
    parameter int unsigned FADE_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          video_enable,
    input  logic [COLSPC-1:0]             pixel,
    input  logic [level_w(FADE_LOG2)-1:0] level,
    output logic [COLSPC-1:0]             scaled
);

    localparam int unsigned PW = COLSPC + FADE_LOG2 + 1;

    logic [PW-1:0] product;

    assign product = PW'(pixel) * PW'(level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scaled <= '0;
        end else begin
            scaled <= video_enable ? COLSPC'(product >> FADE_LOG2) : '0;
        end
    end

endmodule

// File: rtl/demo_sequencer.sv
// Frame-synchronous demo scheduler: dwell, fade out, swap source on a frame boundary, fade in.
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int unsigned NUM_DEMOS    = 4,
    parameter int unsigned COLSPC       = 10,
    parameter int unsigned DWELL_FRAMES = 600,
    parameter int unsigned FADE_LOG2    = 4
) (
    input  logic                           video_clk_pix,
    input  logic                           reset,
    input  logic                           video_enable,
    input  logic                           frame_start,
    input  logic                           auto_enable,
    input  logic                           btn_next,
    input  logic                           btn_prev,
    input  logic [NUM_DEMOS*COLSPC-1:0]    src_red,
    input  logic [NUM_DEMOS*COLSPC-1:0]    src_green,
    input  logic [NUM_DEMOS*COLSPC-1:0]    src_blue,
    output logic [COLSPC-1:0]              red,
    output logic [COLSPC-1:0]              green,
    output logic [COLSPC-1:0]              blue,
    output logic [$clog2(NUM_DEMOS)-1:0]   demo_sel,
    output logic                           busy
);

    localparam int unsigned LW = level_w(FADE_LOG2);
    localparam int unsigned IW = $clog2(NUM_DEMOS);
    localparam int unsigned DW = idx_w(DWELL_FRAMES);
    localparam logic [LW-1:0] FULL       = LW'(2 ** FADE_LOG2);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [IW-1:0] LAST_DEMO  = IW'(NUM_DEMOS - 1);

    demo_state_t   state, state_n;
    logic [LW-1:0] level, level_n;
    logic [IW-1:0] sel_n;
    logic [DW-1:0] dwell, dwell_n;
    logic          pending, pending_n;
    logic          pending_dir, dir_n;   // 1 = previous demo
    logic          busy_n;
    logic          req, pend_eff, prev_eff;

    logic [COLSPC-1:0] pix_r, pix_g, pix_b;

    always_ff @(posedge video_clk_pix or posedge reset) begin
        if (reset) begin
            state       <= SHOW;
            level       <= FULL;
            demo_sel    <= '0;
            dwell       <= '0;
            pending     <= 1'b0;
            pending_dir <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            level       <= level_n;
            demo_sel    <= sel_n;
            dwell       <= dwell_n;
            pending     <= pending_n;
            pending_dir <= dir_n;
            busy        <= busy_n;
        end
    end

    // Simultaneous next+prev cancel; a request on a frame_start cycle is honoured by it.
    always_comb begin
        req       = btn_next ^ btn_prev;
        pend_eff  = pending | req;
        prev_eff  = req ? btn_prev : pending_dir;
        state_n   = state;
        level_n   = level;
        sel_n     = demo_sel;
        dwell_n   = dwell;
        pending_n = pending;
        dir_n     = pending_dir;
        if (req) begin
            pending_n = 1'b1;
            dir_n     = btn_prev;
        end
        if (frame_start) begin
            case (state)
                SHOW: begin
                    if (pend_eff || (auto_enable && (dwell == DWELL_LAST))) begin
                        state_n = FADE_OUT;
                        level_n = FULL - LW'(1);
                        dwell_n = '0;
                    end else if (dwell != DWELL_LAST) begin
                        dwell_n = dwell + DW'(1);
                    end
                end
                FADE_OUT: begin
                    level_n = level - LW'(1);
                    if (level == LW'(1)) state_n = SWAP;
                end
                SWAP: begin
                    state_n   = FADE_IN;
                    level_n   = LW'(1);
                    pending_n = 1'b0;
                    if (pend_eff && prev_eff) begin
                        sel_n = (demo_sel == '0) ? LAST_DEMO : demo_sel - IW'(1);
                    end else begin
                        sel_n = (demo_sel == LAST_DEMO) ? '0 : demo_sel + IW'(1);
                    end
                end
                FADE_IN: begin
                    level_n = level + LW'(1);
                    if (level == FULL - LW'(1)) begin
                        state_n = SHOW;
                        dwell_n = '0;
                    end
                end
                default: state_n = SHOW;
            endcase
        end
        busy_n = (state_n != SHOW);
    end

    // Source mux for the currently selected demo.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        for (int i = 0; i < NUM_DEMOS; i++) begin
            if (demo_sel == IW'(i)) begin
                pix_r = src_red[i*COLSPC +: COLSPC];
                pix_g = src_green[i*COLSPC +: COLSPC];
                pix_b = src_blue[i*COLSPC +: COLSPC];
            end
        end
    end

    demo_fade_scaler #(.COLSPC(COLSPC), .FADE_LOG2(FADE_LOG2)) u_scale_r (
        .clk(video_clk_pix), .rst(reset), .video_enable(video_enable),
        .pixel(pix_r), .level(level), .scaled(red)
    );

    demo_fade_scaler #(.COLSPC(COLSPC), .FADE_LOG2(FADE_LOG2)) u_scale_g (
        .clk(video_clk_pix), .rst(reset), .video_enable(video_enable),
        .pixel(pix_g), .level(level), .scaled(green)
    );

    demo_fade_scaler #(.COLSPC(COLSPC), .FADE_LOG2(FADE_LOG2)) u_scale_b (
        .clk(video_clk_pix), .rst(reset), .video_enable(video_enable),
        .pixel(pix_b), .level(level), .scaled(blue)
    );

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer with NUM_DEMOS=3, DWELL_FRAMES=4, FADE_LOG2=2.
module tb_demo_sequencer;

    localparam int unsigned NUM_DEMOS = 3;
    localparam int unsigned COLSPC    = 10;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        video_enable;
    logic                        frame_start;
    logic                        auto_enable;
    logic                        btn_next;
    logic                        btn_prev;
    logic [NUM_DEMOS*COLSPC-1:0] src_red;
    logic [NUM_DEMOS*COLSPC-1:0] src_green;
    logic [NUM_DEMOS*COLSPC-1:0] src_blue;
    logic [COLSPC-1:0]           red, green, blue;
    logic [1:0]                  demo_sel;
    logic                        busy;

    int n_vec = 0;
    int n_err = 0;

    demo_sequencer #(
        .NUM_DEMOS(NUM_DEMOS), .COLSPC(COLSPC), .DWELL_FRAMES(4), .FADE_LOG2(2)
    ) dut (
        .video_clk_pix(clk), .reset(reset), .video_enable(video_enable),
        .frame_start(frame_start), .auto_enable(auto_enable),
        .btn_next(btn_next), .btn_prev(btn_prev),
        .src_red(src_red), .src_green(src_green), .src_blue(src_blue),
        .red(red), .green(green), .blue(blue),
        .demo_sel(demo_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    // One frame_start pulse, then one idle cycle so the output reflects the new level.
    task automatic do_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) do_frame();
    endtask

    task automatic press(input logic n, input logic p);
        @(negedge clk);
        btn_next = n;
        btn_prev = p;
        @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (red !== 10'd0) begin n_err++; $display("FAIL reset_red: got %0d expected 0", red); end
        n_vec++; if (demo_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", demo_sel); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (red !== 10'd1000) begin n_err++; $display("FAIL reset_full_red: got %0d expected 1000", red); end
        n_vec++; if (green !== 10'd1023) begin n_err++; $display("FAIL reset_full_green: got %0d expected 1023", green); end
    endtask

    task automatic test_pixel_latency();
        @(negedge clk);
        src_red[9:0] = 10'd400;
        #1;
        n_vec++; if (red !== 10'd1000) begin n_err++; $display("FAIL lat_before: got %0d expected 1000", red); end
        @(negedge clk);
        n_vec++; if (red !== 10'd400) begin n_err++; $display("FAIL lat_after: got %0d expected 400", red); end
        video_enable = 1'b0;
        @(negedge clk);
        n_vec++; if (red !== 10'd0) begin n_err++; $display("FAIL lat_blank: got %0d expected 0", red); end
        video_enable = 1'b1;
        src_red[9:0] = 10'd1000;
        @(negedge clk);
        n_vec++; if (red !== 10'd1000) begin n_err++; $display("FAIL lat_restore: got %0d expected 1000", red); end
    endtask

    task automatic test_auto_advance();
        int exp_red [11]  = '{1000, 1000, 1000, 750, 500, 250, 0, 50, 100, 150, 200};
        int exp_sel [11]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        int exp_busy [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        auto_enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            do_frame();
            n_vec++; if (red !== 10'(exp_red[i])) begin n_err++; $display("FAIL auto_red[%0d]: got %0d expected %0d", i, red, exp_red[i]); end
            n_vec++; if (demo_sel !== 2'(exp_sel[i])) begin n_err++; $display("FAIL auto_sel[%0d]: got %0d expected %0d", i, demo_sel, exp_sel[i]); end
            n_vec++; if (busy !== 1'(exp_busy[i])) begin n_err++; $display("FAIL auto_busy[%0d]: got %0b expected %0d", i, busy, exp_busy[i]); end
            if (i == 3) begin
                n_vec++; if (green !== 10'd767) begin n_err++; $display("FAIL auto_green: got %0d expected 767", green); end
            end
        end
        auto_enable = 1'b0;
    endtask

    task automatic test_manual_prev();
        press(1'b0, 1'b1);
        run_frames(8);
        n_vec++; if (demo_sel !== 2'd0) begin n_err++; $display("FAIL prev1_sel: got %0d expected 0", demo_sel); end
        run_frames(20);
        n_vec++; if (demo_sel !== 2'd0) begin n_err++; $display("FAIL hold_sel: got %0d expected 0", demo_sel); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_busy: got %0b expected 0", busy); end
        press(1'b0, 1'b1);
        do_frame();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL prev2_busy: got %0b expected 1", busy); end
        n_vec++; if (red !== 10'd750) begin n_err++; $display("FAIL prev2_red: got %0d expected 750", red); end
        run_frames(7);
        n_vec++; if (demo_sel !== 2'd2) begin n_err++; $display("FAIL wrap_sel: got %0d expected 2", demo_sel); end
        n_vec++; if (red !== 10'd800) begin n_err++; $display("FAIL wrap_red: got %0d expected 800", red); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1);
        run_frames(3);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL both_busy: got %0b expected 0", busy); end
        n_vec++; if (demo_sel !== 2'd2) begin n_err++; $display("FAIL both_sel: got %0d expected 2", demo_sel); end
    endtask

    task automatic test_dir_override();
        press(1'b1, 1'b0);
        do_frame();
        press(1'b1, 1'b0);
        run_frames(3);
        n_vec++; if (red !== 10'd0) begin n_err++; $display("FAIL swap_red: got %0d expected 0", red); end
        press(1'b0, 1'b1);
        run_frames(4);
        n_vec++; if (demo_sel !== 2'd1) begin n_err++; $display("FAIL override_sel: got %0d expected 1", demo_sel); end
        n_vec++; if (red !== 10'd200) begin n_err++; $display("FAIL override_red: got %0d expected 200", red); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL override_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_fade_in_request();
        press(1'b1, 1'b0);
        run_frames(5);
        n_vec++; if (red !== 10'd200) begin n_err++; $display("FAIL fadein_red: got %0d expected 200", red); end
        press(1'b1, 1'b0);
        run_frames(3);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_show_busy: got %0b expected 0", busy); end
        n_vec++; if (red !== 10'd800) begin n_err++; $display("FAIL held_show_red: got %0d expected 800", red); end
        do_frame();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL held_start_busy: got %0b expected 1", busy); end
        n_vec++; if (red !== 10'd600) begin n_err++; $display("FAIL held_start_red: got %0d expected 600", red); end
        run_frames(7);
        n_vec++; if (demo_sel !== 2'd0) begin n_err++; $display("FAIL held_sel: got %0d expected 0", demo_sel); end
        n_vec++; if (red !== 10'd1000) begin n_err++; $display("FAIL held_red: got %0d expected 1000", red); end
    endtask

    task automatic test_reset_mid_fade();
        press(1'b1, 1'b0);
        run_frames(8);
        press(1'b1, 1'b0);
        run_frames(4);
        n_vec++; if (demo_sel !== 2'd1) begin n_err++; $display("FAIL pre_rst_sel: got %0d expected 1", demo_sel); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_rst_busy: got %0b expected 1", busy); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (demo_sel !== 2'd0) begin n_err++; $display("FAIL rst_sel: got %0d expected 0", demo_sel); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_vec++; if (red !== 10'd0) begin n_err++; $display("FAIL rst_red: got %0d expected 0", red); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (red !== 10'd0) begin n_err++; $display("FAIL rel_red: got %0d expected 0", red); end
        @(negedge clk);
        n_vec++; if (red !== 10'd1000) begin n_err++; $display("FAIL rel_full_red: got %0d expected 1000", red); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rel_busy: got %0b expected 0", busy); end
    endtask

    initial begin
        reset        = 1'b1;
        video_enable = 1'b1;
        frame_start  = 1'b0;
        auto_enable  = 1'b0;
        btn_next     = 1'b0;
        btn_prev     = 1'b0;
        src_red      = {10'd800, 10'd200, 10'd1000};
        src_green    = {10'd5, 10'd6, 10'd1023};
        src_blue     = {10'd0, 10'd0, 10'd512};
        test_reset();
        test_pixel_latency();
        test_auto_advance();
        test_manual_prev();
        test_simultaneous();
        test_dir_override();
        test_fade_in_request();
        test_reset_mid_fade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
